prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter NUMWORDS, default 32, SHALL set the instruction memory depth in words.
REQ-002 Parameter DATAWIDTH, default 32, SHALL set the word width; only 32 is supported.
REQ-003 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start_i  input  1  SHALL be a one-cycle pulse that begins a load session.
REQ-006 byte_valid_i  input  1  SHALL mark byte_data_i valid.
REQ-007 byte_data_i  input  8  SHALL carry the incoming program stream byte.
REQ-008 byte_ready_o  output  1  SHALL signal the loader accepts a byte; a transfer occurs when valid and ready are both high on a clock edge.
REQ-009 we_o  output  1  SHALL be the instruction-memory write enable.
REQ-010 waddr_o  output  32  SHALL be the byte write address (word index times 4).
REQ-011 wdata_o  output  DATAWIDTH  SHALL be the assembled write word.
REQ-012 cpu_rst_o  output  1  SHALL hold the CPU in reset (active-high) while no valid program is loaded.
REQ-013 done_o  output  1  SHALL be high while a load has completed successfully.
REQ-014 err_o  output  1  SHALL be high while the last load failed.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
REQ-016 IDLE/DONE/ERR: start_i SHALL move to LEN next cycle, clearing done_o, err_o, word counter and byte counter; start_i in any other state SHALL be ignored.
REQ-017 LEN: byte_ready_o high; accepted byte N in 1..NUMWORDS SHALL be latched as word count and move to DATA; N=0 or N>NUMWORDS SHALL move to ERR.
REQ-018 DATA: byte_ready_o high; bytes SHALL assemble little-endian (first byte to bits 7:0); on the 4th byte move to WRITE.
REQ-019 WRITE: byte_ready_o low; we_o high for exactly one cycle with waddr_o = 4*word index, wdata_o = assembled word; word index then increments.
REQ-020 After WRITE, if word index equals N the FSM SHALL go to CHK (macro defined) or DONE (macro undefined); otherwise back to DATA.
REQ-021 we_o SHALL be low in every state except WRITE; waddr_o/wdata_o SHALL hold their last values otherwise.
REQ-022 cpu_rst_o SHALL be high in every state except DONE; it SHALL fall the cycle the FSM enters DONE.
REQ-023 byte_valid_i low SHALL stall the FSM without changing any counter; no timeout exists.
REQ-024 Bytes presented while byte_ready_o is low SHALL not be consumed.
REQ-025 Word index SHALL never exceed NUMWORDS-1 on waddr_o; no wrap-around occurs because N is bounded in LEN.

Reset
REQ-026 rst_ni low SHALL immediately force IDLE, byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, cpu_rst_o=1, done_o=0, err_o=0, counters and checksum to 0, including mid-session.
REQ-027 Release of rst_ni SHALL leave the block in IDLE awaiting start_i; memory contents written earlier are not the block's concern.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: a running XOR of all DATA bytes SHALL be kept; CHK state accepts one byte, equal -> DONE, unequal -> ERR (cpu_rst_o stays high).
REQ-029 Macro LOADER_CHECKSUM_EN undefined: CHK state and checksum register SHALL not exist; last WRITE goes directly to DONE.

Verification
REQ-030 Reset then start, stream 01, 13 00 00 00 (checksum 13 if enabled) -> one we_o pulse, waddr_o=0, wdata_o=0x00000013, done_o=1, cpu_rst_o=0.
REQ-031 Stream N=3 with 12 bytes, byte_valid_i toggled every other cycle -> three writes at addresses 0,4,8 with correct words; no byte lost or duplicated.
REQ-032 Length byte 0x00, then 0x21 with NUMWORDS=32 -> ERR, err_o=1, cpu_rst_o=1, no we_o pulse.
REQ-033 Checksum enabled, N=1 word 0xDEADBEEF, checksum byte 0x00 (correct is 0x22) -> ERR, err_o=1; repeat with 0x22 -> DONE.
REQ-034 Assert rst_ni low after 2 of 4 data bytes -> all outputs at reset values asynchronously; new start and full stream then completes normally.
REQ-035 start_i pulsed during DATA -> ignored, session completes; start_i in DONE -> cpu_rst_o=1 and done_o=0 next cycle.

Source files
------------

// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Brief    : Streams a length-prefixed byte program into instruction memory
//             and holds the CPU in reset until a complete program is loaded.
//             Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
   parameter int NUMWORDS  = 32,
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_data_i,
   output logic                 byte_ready_o,
   output logic                 we_o,
   output logic [31:0]          waddr_o,
   output logic [DATAWIDTH-1:0] wdata_o,
   output logic                 cpu_rst_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int c_cw = $clog2(NUMWORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
      , S_CHK = 3'd6
`endif
   } state_t;

   state_t                r_state;
   logic [c_cw-1:0]       r_len;
   logic [c_cw-1:0]       r_word_idx;
   logic [1:0]            r_byte_cnt;
   logic [DATAWIDTH-1:0]  r_asm;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            r_csum;
`endif

   logic                  w_xfer;
   logic                  w_len_ok;
   logic [c_cw-1:0]       w_idx_next;
   logic [DATAWIDTH-1:0]  w_asm_next;

   assign w_xfer     = byte_valid_i & byte_ready_o;
   assign w_len_ok   = (byte_data_i != 8'd0) && ({24'd0, byte_data_i} <= 32'(NUMWORDS));
   assign w_idx_next = r_word_idx + c_cw'(1);
   // Little-endian assembly: after four shifts the first byte sits in bits 7:0.
   assign w_asm_next = {byte_data_i, r_asm[DATAWIDTH-1:8]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_word_idx   <= '0;
         r_byte_cnt   <= '0;
         r_asm        <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum       <= '0;
`endif
         byte_ready_o <= 1'b0;
         we_o         <= 1'b0;
         waddr_o      <= '0;
         wdata_o      <= '0;
         cpu_rst_o    <= 1'b1;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         we_o <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  r_state      <= S_LEN;
                  r_word_idx   <= '0;
                  r_byte_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
                  r_csum       <= '0;
`endif
                  byte_ready_o <= 1'b1;
                  cpu_rst_o    <= 1'b1;
                  done_o       <= 1'b0;
                  err_o        <= 1'b0;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  if (w_len_ok) begin
                     r_len   <= c_cw'(byte_data_i);
                     r_state <= S_DATA;
                  end else begin
                     r_state      <= S_ERR;
                     byte_ready_o <= 1'b0;
                     err_o        <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_asm      <= w_asm_next;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  r_csum     <= r_csum ^ byte_data_i;
`endif
                  if (r_byte_cnt == 2'd3) begin
                     r_state      <= S_WRITE;
                     byte_ready_o <= 1'b0;
                     we_o         <= 1'b1;
                     waddr_o      <= 32'({r_word_idx, 2'b00});
                     wdata_o      <= w_asm_next;
                  end
               end
            end
            S_WRITE: begin
               r_word_idx <= w_idx_next;
               if (w_idx_next == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state      <= S_CHK;
                  byte_ready_o <= 1'b1;
`else
                  r_state      <= S_DONE;
                  done_o       <= 1'b1;
                  cpu_rst_o    <= 1'b0;
`endif
               end else begin
                  r_state      <= S_DATA;
                  byte_ready_o <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (w_xfer) begin
                  byte_ready_o <= 1'b0;
                  if (byte_data_i == r_csum) begin
                     r_state   <= S_DONE;
                     done_o    <= 1'b1;
                     cpu_rst_o <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     err_o   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               r_state      <= S_IDLE;
               byte_ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module   : tb_prog_loader
//  Brief    : Directed self-checking bench for prog_loader with a write
//             scoreboard. Honours LOADER_CHECKSUM_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

   localparam int NW = 32;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        start_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'd0;
   logic        byte_ready_o;
   logic        we_o;
   logic [31:0] waddr_o;
   logic [31:0] wdata_o;
   logic        cpu_rst_o;
   logic        done_o;
   logic        err_o;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];
   int          widx = 0;
   logic [7:0]  csum = 8'd0;

   always #5 clk_i = ~clk_i;

   prog_loader #(.NUMWORDS(NW), .DATAWIDTH(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .cpu_rst_o    (cpu_rst_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the oldest pending expectation.
   always @(negedge clk_i) begin
      if (rst_ni && we_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_we", {31'd0, we_o}, 32'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("waddr", waddr_o, e[63:32]);
            check("wdata", wdata_o, e[31:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
      check({tag, "_we"},    {31'd0, we_o},         32'd0);
      check({tag, "_waddr"}, waddr_o,               32'd0);
      check({tag, "_wdata"}, wdata_o,               32'd0);
      check({tag, "_cpurst"},{31'd0, cpu_rst_o},    32'd1);
      check({tag, "_done"},  {31'd0, done_o},       32'd0);
      check({tag, "_err"},   {31'd0, err_o},        32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int   n;
      logic rdy;
      n = 0;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      do begin
         rdy = byte_ready_o;
         @(negedge clk_i);
         n++;
      end while (!rdy && n < 100);
      if (!rdy) check("byte_accept", {31'd0, rdy}, 32'd1);
      byte_valid_i = 1'b0;
      if (gap) @(negedge clk_i);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      exp_q.push_back({32'(widx * 4), w});
      widx++;
      for (int i = 0; i < 4; i++) begin
         csum = csum ^ w[8*i +: 8];
         send_byte(w[8*i +: 8], gap);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic start_session();
      pulse_start();
      widx = 0;
      csum = 8'd0;
   endtask

   task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
      send_byte(csum, 1'b0);
`endif
   endtask

   task automatic expect_end(input string tag, input bit ok);
      int n;
      n = 0;
      while (done_o !== 1'b1 && err_o !== 1'b1 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_done"},   {31'd0, done_o},    {31'd0, ok});
      check({tag, "_err"},    {31'd0, err_o},     {31'd0, !ok});
      check({tag, "_cpurst"}, {31'd0, cpu_rst_o}, {31'd0, !ok});
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] w;

      // Power-on reset
      #2 rst_ni = 1'b0;
      #1 check_reset_vals("por");
      @(negedge clk_i);
      @(negedge clk_i);
      check_reset_vals("por_hold");
      rst_ni = 1'b1;
      @(negedge clk_i);
      check({"idle_ready"}, {31'd0, byte_ready_o}, 32'd0);

      // Single-word program
      start_session();
      send_byte(8'd1, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      send_chk();
      expect_end("one_word", 1'b1);

      // Three words with byte_valid_i toggling
      start_session();
      send_byte(8'd3, 1'b1);
      send_word(32'h0403_0201, 1'b1);
      send_word(32'h0807_0605, 1'b1);
      send_word(32'h0C0B_0A09, 1'b1);
      send_chk();
      expect_end("three_words", 1'b1);

      // Bad lengths
      start_session();
      send_byte(8'h00, 1'b0);
      expect_end("len_zero", 1'b0);
      start_session();
      send_byte(8'h21, 1'b0);
      expect_end("len_over", 1'b0);

      // Largest legal length reaches the top word address
      start_session();
      send_byte(8'(NW), 1'b0);
      for (int i = 0; i < NW; i++) begin
         w = $urandom;
         send_word(w, 1'b0);
      end
      send_chk();
      expect_end("len_max", 1'b1);

`ifdef LOADER_CHECKSUM_EN
      start_session();
      send_byte(8'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      check("csum_model", {24'd0, csum}, 32'h22);
      send_byte(8'h00, 1'b0);
      expect_end("csum_bad", 1'b0);
      start_session();
      send_byte(8'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_byte(8'h22, 1'b0);
      expect_end("csum_good", 1'b1);
`else
      start_session();
      send_byte(8'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      expect_end("deadbeef", 1'b1);
`endif

      // Reset mid-word, then a clean session
      start_session();
      send_byte(8'd1, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      #2 rst_ni = 1'b0;
      #1 check_reset_vals("mid_rst");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_rst_ready", {31'd0, byte_ready_o}, 32'd0);
      start_session();
      send_byte(8'd1, 1'b0);
      send_word(32'hA5A5_5A5A, 1'b0);
      send_chk();
      expect_end("after_rst", 1'b1);

      // start_i during DATA is ignored; start_i in DONE restarts
      start_session();
      send_byte(8'd2, 1'b0);
      send_word(32'h1234_5678, 1'b0);
      @(negedge clk_i);
      pulse_start();
      send_word(32'h9ABC_DEF0, 1'b0);
      send_chk();
      expect_end("start_in_data", 1'b1);
      start_session();
      check("restart_cpurst", {31'd0, cpu_rst_o}, 32'd1);
      check("restart_done",   {31'd0, done_o},    32'd0);
      send_byte(8'h00, 1'b0);
      expect_end("restart_err", 1'b0);

      repeat (3) @(negedge clk_i);
      check("final_pending", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
